// File: rtl/arb8_rr.sv
// Eight-way bus arbiter with fixed-priority or round-robin selection.
// Registered one-hot grant, held until release or hold-limit preemption.
module arb8_rr #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] id_q, id_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] last_q, last_d;

    logic [7:0] cand;
    logic [7:0] arb_v;
    logic [2:0] win;
    logic       take;

    // Fixed: highest set index. Round-robin: first set bit after `last`.
    function automatic logic [2:0] pick(
        input logic [7:0] v,
        input logic       rr,
        input logic [2:0] last
    );
        logic [2:0] w;
        logic [2:0] idx;
        logic       found;
        w     = '0;
        found = 1'b0;
        if (!rr) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) w = 3'(i);
            end
        end else begin
            for (int k = 1; k <= 8; k++) begin
                idx = last + 3'(k);
                if (v[idx] && !found) begin
                    w     = idx;
                    found = 1'b1;
                end
            end
        end
        return w;
    endfunction

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        take    = 1'b0;
        cand    = req & ~gnt_q;
        arb_v   = (state_q == IDLE) ? req : cand;
        win     = pick(arb_v, mode, last_q);
        unique case (state_q)
            IDLE: begin
                if (|req) take = 1'b1;
            end
            GRANT: begin
                if (!req[id_q] || (cnt_q == HOLD_LAST && |cand)) begin
                    if (|cand) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
        if (take) begin
            state_d = GRANT;
            gnt_d   = 8'b1 << win;
            id_d    = win;
            last_d  = win;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 3'd7;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = id_q;
    assign busy   = |gnt_q;

endmodule

// File: tb/tb_arb8_rr.sv
// Bench for arb8_rr: three hold limits driven in parallel, directed
// vectors plus random traffic against an ownership-level model.
module tb_arb8_rr;

    logic            clk;
    logic            reset;
    logic [7:0]      req;
    logic            mode;
    logic [2:0][7:0] gw;
    logic [2:0][2:0] iw;
    logic [2:0]      bw;

    int checks;
    int failures;

    int HOLD [3] = '{1, 4, 16};
    int own  [3];
    int held [3];
    int lst  [3];
    int mid  [3];

    arb8_rr #(.MAX_HOLD(1)) u_h1 (
        .clk(clk), .reset(reset), .req(req), .mode(mode),
        .gnt(gw[0]), .gnt_id(iw[0]), .busy(bw[0])
    );
    arb8_rr #(.MAX_HOLD(4)) u_h4 (
        .clk(clk), .reset(reset), .req(req), .mode(mode),
        .gnt(gw[1]), .gnt_id(iw[1]), .busy(bw[1])
    );
    arb8_rr #(.MAX_HOLD(16)) u_h16 (
        .clk(clk), .reset(reset), .req(req), .mode(mode),
        .gnt(gw[2]), .gnt_id(iw[2]), .busy(bw[2])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       md;
        logic [7:0] rq;
        logic [7:0] exp_gnt;
    } vec_t;

    vec_t tbl [19];

    task automatic check8(input string nm, input logic [7:0] act,
                          input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic int pick(input logic [7:0] v, input logic md,
                                input int l);
        if (!md) begin
            for (int i = 7; i >= 0; i--) if (v[i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++)
                if (v[(l + k) % 8]) return (l + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input int p);
        logic [7:0] cand;
        int w;
        if (reset) begin
            own[p]  = -1;
            held[p] = 0;
            lst[p]  = 7;
            mid[p]  = 0;
        end else if (own[p] < 0) begin
            if (req != 0) begin
                w = pick(req, mode, lst[p]);
                own[p] = w; held[p] = 1; lst[p] = w; mid[p] = w;
            end
        end else begin
            cand = req & ~(8'b1 << own[p]);
            if (!req[own[p]] || (held[p] >= HOLD[p] && cand != 0)) begin
                if (cand != 0) begin
                    w = pick(cand, mode, lst[p]);
                    own[p] = w; held[p] = 1; lst[p] = w; mid[p] = w;
                end else begin
                    own[p] = -1;
                end
            end else begin
                held[p]++;
            end
        end
    endtask

    task automatic cyc();
        logic [7:0] eg;
        for (int p = 0; p < 3; p++) model_step(p);
        @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) begin
            eg = (own[p] >= 0) ? (8'b1 << own[p]) : 8'h00;
            check8($sformatf("model_gnt_h%0d", HOLD[p]), gw[p], eg);
            check8($sformatf("model_busy_h%0d", HOLD[p]),
                   {7'b0, bw[p]}, {7'b0, own[p] >= 0});
            check8($sformatf("model_id_h%0d", HOLD[p]),
                   {5'b0, iw[p]}, 8'(mid[p]));
        end
    endtask

    initial begin
        clk      = 0;
        reset    = 1;
        req      = 0;
        mode     = 0;
        checks   = 0;
        failures = 0;
        for (int p = 0; p < 3; p++) begin
            own[p] = -1; held[p] = 0; lst[p] = 7; mid[p] = 0;
        end

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 8'h24, 8'h20};
        tbl[2]  = '{1'b0, 1'b0, 8'h04, 8'h04};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 8'h01, 8'h01};
        tbl[5]  = '{1'b0, 1'b0, 8'h81, 8'h01};
        tbl[6]  = '{1'b0, 1'b0, 8'h81, 8'h01};
        tbl[7]  = '{1'b0, 1'b0, 8'h81, 8'h01};
        tbl[8]  = '{1'b0, 1'b0, 8'h81, 8'h80};
        tbl[9]  = '{1'b0, 1'b0, 8'h01, 8'h01};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 8'h00};
        tbl[11] = '{1'b0, 1'b0, 8'h40, 8'h40};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h00};
        tbl[13] = '{1'b0, 1'b1, 8'h41, 8'h01};
        tbl[14] = '{1'b0, 1'b1, 8'h00, 8'h00};
        tbl[15] = '{1'b0, 1'b1, 8'hFF, 8'h02};
        tbl[16] = '{1'b1, 1'b1, 8'hFF, 8'h00};
        tbl[17] = '{1'b0, 1'b1, 8'hFF, 8'h01};
        tbl[18] = '{1'b0, 1'b1, 8'h00, 8'h00};

        cyc();
        check8("reset_id", {5'b0, iw[1]}, 8'h00);

        // Directed table on the MAX_HOLD=4 instance
        for (int i = 0; i < 19; i++) begin
            reset = tbl[i].rst;
            mode  = tbl[i].md;
            req   = tbl[i].rq;
            cyc();
            check8($sformatf("tbl%0d_gnt", i), gw[1], tbl[i].exp_gnt);
            check8($sformatf("tbl%0d_busy", i), {7'b0, bw[1]},
                   {7'b0, |tbl[i].exp_gnt});
        end

        // Strict rotation with MAX_HOLD=1
        reset = 1;
        req   = 0;
        cyc();
        reset = 0;
        mode  = 1;
        req   = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            cyc();
            check8($sformatf("rot%0d_id", i), {5'b0, iw[0]}, 8'(i % 8));
            check8($sformatf("rot%0d_gnt", i), gw[0], 8'b1 << (i % 8));
        end

        // Lone requester survives timeout, then is preempted
        req  = 0;
        mode = 0;
        cyc();
        cyc();
        req = 8'h10;
        for (int i = 0; i < 100; i++) begin
            cyc();
            check8($sformatf("solo%0d", i), gw[2], 8'h10);
        end
        req = 8'h12;
        cyc();
        check8("preempt_gnt", gw[2], 8'h02);
        check8("preempt_id", {5'b0, iw[2]}, 8'h01);
        req = 0;
        cyc();
        check8("preempt_idle", gw[2], 8'h00);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    req = 8'($urandom) & 8'($urandom);
                else
                    req = 8'($urandom);
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb8_rr.md
# arb8_rr

Eight-way bus arbiter that shares one downstream resource among eight requesters. Selects a winner in either fixed-priority mode (bit 7 highest, same ordering as `priority8`) or round-robin mode. Holds the grant until the owner releases or a hold-limit timer expires under contention. Grants are registered, one-hot, and never overlap.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles while another requester is waiting; legal range 1..255.
- `clk` input 1: clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req` input 8: request vector; `req[i]` stays high while requester i wants or uses the resource.
- `mode` input 1: 0 = fixed priority, 1 = round-robin; sampled only at arbitration points.
- `gnt` output 8: one-hot grant, or all zero; registered.
- `gnt_id` output 3: binary index of the current owner; registered; valid while `busy`=1.
- `busy` output 1: 1 while any grant is active; equals `|gnt`.

## Operation
- Reset values: `gnt`=8'h00, `gnt_id`=0, `busy`=0, hold counter=0, round-robin pointer `last`=7, state IDLE.
- States:
  - IDLE: no grant. If `req`≠0, arbitrate over `req` and go to GRANT with the winner. Otherwise stay.
  - GRANT: owner held. Hold counter increments each cycle and saturates at `MAX_HOLD`-1.
- Release conditions in GRANT, evaluated every cycle:
  - (a) `req[owner]`=0.
  - (b) Hold counter = `MAX_HOLD`-1 and (`req` & ~`gnt`)≠0.
- On release:
  - Let `cand` = `req` & ~`gnt`.
  - If `cand`≠0: arbitrate over `cand`, grant the new winner the next cycle with no idle gap, and clear the hold counter.
  - Else go to IDLE.
- Timeout with no other requester: owner keeps the grant and the counter stays saturated. A later request from another requester preempts the owner on the next cycle.
- Arbitration rules:
  - Fixed (`mode`=0): the highest set index wins.
  - Round-robin (`mode`=1): search ascending from (`last`+1) mod 8 with wrap; the first set bit wins.
  - `last` updates to the winner index on every new grant in both modes.
- A requester that drops and re-raises `req` while not owner has no special status.
- `req` bits for a non-owner may toggle freely. Only the owner's bit and the `cand` vector affect the state.
- `mode` changes during GRANT have no effect until the next arbitration point.

## Timing
- Request to grant latency: `req` first high in cycle t with state IDLE gives `gnt`/`gnt_id`/`busy` in cycle t+1.
- Handover: owner drops `req` in cycle t, or a timeout condition holds in cycle t. The old grant is low and the new grant high in cycle t+1. One-hot is maintained and there is no overlap.
- Under contention, an owner that never drops `req` holds `gnt` for exactly `MAX_HOLD` consecutive cycles.
- `MAX_HOLD`=1: a contended grant lasts exactly one cycle, giving strict rotation in round-robin mode.
- Owner drops `req` with no other request pending: `gnt`=0 and `busy`=0 in cycle t+1.
- `reset` high in any cycle: all outputs at reset values in the next cycle regardless of state. `reset` takes priority over simultaneous requests.
- The same-cycle release of one owner and arbitration among the others is a single arbitration. The released owner is excluded from the winner set for that cycle only.

## Test plan
- Reset, then `mode`=0, `req`=8'b0010_0100 → next cycle `gnt`=8'b0010_0000, `gnt_id`=5, `busy`=1. Drop `req[5]` → next cycle `gnt`=8'b0000_0100, `gnt_id`=2.
- `mode`=1, `req`=8'hFF held constant, `MAX_HOLD`=1 → grants cycle 0,1,2,…,7,0 one per cycle, starting at index 0 after reset.
- `MAX_HOLD`=4, `mode`=0, `req`=8'h01 granted, then `req`=8'h81 while idx 0 owns → idx 0 keeps the grant for 4 cycles total, then `gnt`=8'h80. With 8'h01 still high after the 8'h80 owner releases, grant returns to idx 0.
- Single requester held 100 cycles, `req`=8'h10 → `gnt`=8'h10 continuously with no drop at timeout. Raise `req[1]` → `gnt`=8'h02 on the cycle after timeout saturation is observed (next edge).
- Round-robin wrap: `last`=6, `req`=8'b0100_0001 at an arbitration point → winner idx 0 (search order 7,0).
- `reset` asserted mid-GRANT with `req`=8'hFF → next cycle `gnt`=0, `busy`=0. After release, `mode`=1 grants idx 0 first (`last`=7).
